// File: rtl/oled_pkg.sv
// oled_pkg: shared state encoding, ASCII constants and lowest-set-bit helper for the OLED line sequencer
package oled_pkg;
  typedef enum logic [1:0] {IDLE, SELECT, CONVERT, SEND} state_t;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  function automatic int lowest_set(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble, one bit per cycle, done pulses VAL_W cycles after start
module bin2bcd_seq #(
  parameter int VAL_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [VAL_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int CNW = $clog2(VAL_W + 1);
  logic [VAL_W-1:0] sh;
  logic [CNW-1:0] cnt;
  logic run;
  logic [4*DIGITS-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int k = 0; k < DIGITS; k++)
      adj[k*4 +: 4] = bcd[k*4 +: 4] > 4'd4 ? bcd[k*4 +: 4] + 4'd3 : bcd[k*4 +: 4];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sh <= bin;
        bcd <= '0;
        cnt <= CNW'(VAL_W);
        run <= 1'b1;
      end else if (run) begin
        {bcd, sh} <= {adj[4*DIGITS-2:0], sh, 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CNW'(1)) begin
          run <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/oled_line_sequencer.sv
// oled_line_sequencer: redraws dirty label+decimal lines, streaming chars to the OLED writer
module oled_line_sequencer
  import oled_pkg::*;
#(
  parameter int N_LINES = 4,
  parameter int CHARS = 12,
  parameter int VAL_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                refresh,
  input  logic [N_LINES*VAL_W-1:0]            val_in,
  input  logic [N_LINES-1:0]                  num_en,
  input  logic [N_LINES*(CHARS-DIGITS)*8-1:0] label_in,
  input  logic                                char_done,
  output logic                                char_valid,
  output logic [7:0]                          char_data,
  output logic [$clog2(N_LINES)-1:0]          char_row,
  output logic [$clog2(CHARS)-1:0]            char_col,
  output logic                                busy,
  output logic                                frame_done
);
  localparam int LW = CHARS - DIGITS;
  localparam int RW = $clog2(N_LINES);
  localparam int CW = $clog2(CHARS);
  if (10**DIGITS <= 2**VAL_W - 1) begin : g_digits_check
    $error("DIGITS too small to hold the largest VAL_W value");
  end
  state_t state, state_d;
  logic [N_LINES-1:0] dirty, dirty_d, req, own, shadow_en;
  logic [N_LINES*VAL_W-1:0] shadow;
  logic [RW-1:0] row, sel;
  logic [CW-1:0] col;
  logic [4*DIGITS-1:0] bcd;
  logic work_en, conv_done, last, fd_d, blank;
  logic [3:0] nib;
  logic [7:0] ch;
  int lc, k;
  assign sel = RW'(lowest_set(32'(dirty)));
  assign last = col == CW'(CHARS - 1);
  assign char_valid = state == SEND;
  assign busy = state != IDLE;
  assign char_row = row;
  assign char_col = col;
  bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_b2b (
    .clk(clk),
    .rst(rst),
    .start(state == SELECT),
    .bin(val_in[int'(sel)*VAL_W +: VAL_W]),
    .done(conv_done),
    .bcd(bcd)
  );
  // the line being latched in SELECT compares equal to itself, so only refresh can re-dirty it
  always_comb begin
    own = '0;
    req = '0;
    for (int i = 0; i < N_LINES; i++) begin
      own[i] = state == SELECT && int'(sel) == i;
      req[i] = refresh || (!own[i] && ((num_en[i] && val_in[i*VAL_W +: VAL_W] != shadow[i*VAL_W +: VAL_W])
               || num_en[i] != shadow_en[i]));
    end
    dirty_d = req | (dirty & ~own);
  end
  always_comb begin
    state_d = state;
    fd_d = 1'b0;
    unique case (state)
      IDLE:    state_d = |dirty ? SELECT : IDLE;
      SELECT:  state_d = CONVERT;
      CONVERT: state_d = conv_done ? SEND : CONVERT;
      SEND: if (char_done && last) begin
        state_d = |dirty_d ? SELECT : IDLE;
        fd_d = ~|dirty_d;
      end
      default: state_d = IDLE;
    endcase
  end
  // digit k counts from the units digit; leading zeros above the units digit are blanked
  always_comb begin
    lc = int'(col) < LW ? int'(col) : 0;
    k = int'(col) >= LW ? CHARS - 1 - int'(col) : 0;
    nib = bcd[k*4 +: 4];
    blank = !work_en || (k != 0 && (bcd >> (k*4)) == '0);
    ch = int'(col) < LW ? label_in[(int'(row)*LW + LW - 1 - lc)*8 +: 8]
       : blank ? ASCII_SPACE : ASCII_ZERO | {4'h0, nib};
    char_data = char_valid ? ch : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      dirty <= '1;
      shadow <= '0;
      shadow_en <= '0;
      row <= '0;
      col <= '0;
      work_en <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state <= state_d;
      dirty <= dirty_d;
      frame_done <= fd_d;
      if (state == SELECT) begin
        row <= sel;
        col <= '0;
        work_en <= num_en[sel];
        shadow[int'(sel)*VAL_W +: VAL_W] <= val_in[int'(sel)*VAL_W +: VAL_W];
        shadow_en[sel] <= num_en[sel];
      end
      if (char_valid && char_done) col <= last ? '0 : col + 1'b1;
    end
  end
endmodule
